// File: rtl/cpu_debug_monitor.sv
// Debug monitor: run/step control of a CPU core, retired-instruction counter, WWD capture FIFO, register view mux.
// Optional macro WWD_FIFO_HALT_EN: halt the core while the WWD FIFO is full instead of dropping data.
module cpu_debug_monitor #(
    parameter int unsigned WORD_SIZE  = 16,
    parameter int unsigned PC_SIZE    = 8,
    parameter int unsigned NUM_SEL    = 4,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset_cpu,
    input  logic                         cpu_enable,
    input  logic                         step_mode,
    input  logic                         step_req,
    input  logic                         inst_done,
    input  logic [WORD_SIZE-1:0]         pc,
    input  logic                         wwd_valid,
    input  logic [WORD_SIZE-1:0]         wwd_data,
    input  logic [NUM_SEL*WORD_SIZE-1:0] reg_view_data,
    input  logic [$clog2(NUM_SEL)-1:0]   register_selection,
    input  logic                         pop,
    output logic                         cpu_run,
    output logic [WORD_SIZE-1:0]         num_inst,
    output logic [WORD_SIZE-1:0]         output_port,
    output logic [WORD_SIZE-1:0]         reg_view_out,
    output logic [PC_SIZE-1:0]           PC_below_8bit,
    output logic                         fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]  wwd_count,
    output logic                         wwd_overflow
);

    localparam int unsigned SEL_W = $clog2(NUM_SEL);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RUN       = 3'd1,
        STEP_WAIT = 3'd2,
        STEP_RUN  = 3'd3,
        HALT      = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic                   cpu_run_q, cpu_run_d;
    logic                   step_req_q;
    logic                   step_rise;
    logic [WORD_SIZE-1:0]   num_inst_q, num_inst_d;
    logic [PC_SIZE-1:0]     pc_low_q, pc_low_d;
    logic [WORD_SIZE-1:0]   view_q, view_d;
    logic [WORD_SIZE-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [WORD_SIZE-1:0]   head_q, head_d;
    logic                   empty_q, empty_d;
    logic                   overflow_q, overflow_d;
    logic                   fifo_full;
    logic                   rd_en;
    logic                   wr_en;
    logic                   unused_pc;

    assign unused_pc = ^pc;
    assign step_rise = step_req & ~step_req_q;

    // FIFO bookkeeping; a pop frees the slot a same-cycle push needs when full
    always_comb begin
        fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
        rd_en      = pop & (count_q != '0);
        wr_en      = wwd_valid & (~fifo_full | rd_en);
        wr_ptr_d   = wr_ptr_q + PTR_W'(wr_en);
        rd_ptr_d   = rd_ptr_q + PTR_W'(rd_en);
        count_d    = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
        empty_d    = (count_d == '0);
        head_d     = '0;
        if (!empty_d) begin
            // new head may be the entry being written this very edge
            if (wr_en && (wr_ptr_q == rd_ptr_d)) begin
                head_d = wwd_data;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
`ifdef WWD_FIFO_HALT_EN
        overflow_d = 1'b0;
`else
        overflow_d = overflow_q | (wwd_valid & fifo_full & ~rd_en);
`endif
    end

    // run/step control state machine
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cpu_enable) state_d = step_mode ? STEP_WAIT : RUN;
            end
            RUN: begin
                if (!cpu_enable)    state_d = IDLE;
                else if (step_mode) state_d = STEP_WAIT;
            end
            STEP_WAIT: begin
                if (!cpu_enable)     state_d = IDLE;
                else if (step_rise)  state_d = STEP_RUN;
                else if (!step_mode) state_d = RUN;
            end
            STEP_RUN: begin
                if (!cpu_enable)    state_d = IDLE;
                else if (inst_done) state_d = step_mode ? STEP_WAIT : RUN;
            end
            HALT: begin
`ifdef WWD_FIFO_HALT_EN
                if (!cpu_enable)                             state_d = IDLE;
                else if (count_d != CNT_W'(FIFO_DEPTH))      state_d = step_mode ? STEP_WAIT : RUN;
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
`ifdef WWD_FIFO_HALT_EN
        if (cpu_enable && (count_d == CNT_W'(FIFO_DEPTH)) &&
            (state_q == RUN || state_q == STEP_WAIT || state_q == STEP_RUN)) begin
            state_d = HALT;
        end
`endif
        cpu_run_d = (state_d == RUN) || (state_d == STEP_RUN);
    end

    // instruction counter, PC capture and register view
    always_comb begin
        num_inst_d = num_inst_q;
        pc_low_d   = pc_low_q;
        if (inst_done && cpu_run_q) begin
            num_inst_d = num_inst_q + WORD_SIZE'(1);
            pc_low_d   = pc[PC_SIZE-1:0];
        end
        view_d = '0;
        for (int k = 0; k < int'(NUM_SEL); k++) begin
            if (register_selection == SEL_W'(k)) view_d = reg_view_data[k*WORD_SIZE +: WORD_SIZE];
        end
    end

    always_ff @(posedge clk or negedge reset_cpu) begin
        if (!reset_cpu) begin
            state_q    <= IDLE;
            cpu_run_q  <= 1'b0;
            step_req_q <= 1'b0;
            num_inst_q <= '0;
            pc_low_q   <= '0;
            view_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            head_q     <= '0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cpu_run_q  <= cpu_run_d;
            step_req_q <= step_req;
            num_inst_q <= num_inst_d;
            pc_low_q   <= pc_low_d;
            view_q     <= view_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            head_q     <= head_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    // storage needs no reset: pointers and count define validity
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wwd_data;
    end

    assign cpu_run       = cpu_run_q;
    assign num_inst      = num_inst_q;
    assign output_port   = head_q;
    assign reg_view_out  = view_q;
    assign PC_below_8bit = pc_low_q;
    assign fifo_empty    = empty_q;
    assign wwd_count     = count_q;
    assign wwd_overflow  = overflow_q;

endmodule
